// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request, 2-entry PC-tagged
// instruction buffer drained by decode, flush drops buffer and in-flight data.
module ifetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        incr_pc_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  input  logic        instr_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD,
    FAULTED
  } state_t;

  state_t      state, state_n;
  logic [31:0] pend_pc;
  logic [1:0]  cnt;
  logic        rd_ptr, wr_ptr;
  logic [31:0] data_q [2];
  logic [31:0] pc_q   [2];
  logic        flt_q  [2];

  logic        pop, push, out, fire;
  logic [2:0]  occ;

  assign pop  = instr_valid_o & instr_ready_i;
  assign out  = (state == WAIT);
  assign push = out & imem_rvalid_i & ~flush_i;
  // occupancy once the outstanding response lands; a new request needs a slot
  assign occ  = {1'b0, cnt} - {2'b0, pop} + {2'b0, out};

  assign imem_req_o = ~flush_i & (occ < 3'd2)
                    & ((state == IDLE)
                     | (out & imem_rvalid_i & ~imem_err_i));
  assign imem_addr_o = pc_i;
  assign fire        = imem_req_o & imem_gnt_i;
  assign incr_pc_o   = fire;

  always_comb begin
    state_n = state;
    if (flush_i) begin
      case (state)
        WAIT:    state_n = imem_rvalid_i ? IDLE : DISCARD;
        DISCARD: state_n = imem_rvalid_i ? IDLE : DISCARD;
        default: state_n = IDLE;
      endcase
    end else begin
      case (state)
        IDLE:    if (fire) state_n = WAIT;
        WAIT: begin
          if (imem_rvalid_i) begin
            if (imem_err_i)  state_n = FAULTED;
            else if (fire)   state_n = WAIT;
            else             state_n = IDLE;
          end
        end
        DISCARD: if (imem_rvalid_i) state_n = IDLE;
        default: state_n = FAULTED;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pend_pc <= '0;
      cnt     <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else begin
      state <= state_n;
      if (fire) pend_pc <= pc_i;
      if (flush_i) begin
        cnt    <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rdata_i;
      pc_q[wr_ptr]   <= pend_pc;
      flt_q[wr_ptr]  <= imem_err_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push && !pop)
      assert (cnt != 2'd2);
  end

  assign instr_valid_o = (cnt != 2'd0);
  assign instr_pc_o    = instr_valid_o ? pc_q[rd_ptr] : '0;
  assign instr_fault_o = instr_valid_o & flt_q[rd_ptr];
  assign instr_o       = (!instr_valid_o || flt_q[rd_ptr])
                       ? NOP_INSTR : data_q[rd_ptr];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: streaming, backpressure, grant stall,
// flush variants, bus error and mid-WAIT reset.
module tb_ifetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        incr_pc_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_fault_o;
  logic        instr_ready_i;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int passed = 0;
  int total  = 0;

  logic        auto_mem;
  logic [31:0] redir;
  logic [31:0] exp_head;

  ifetch dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_err_i    (imem_err_i),
    .incr_pc_o     (incr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_fault_o (instr_fault_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hAABB_CCDD ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // PC unit and optional memory answering at T+1
  task automatic tick();
    logic        inc, fl;
    logic [31:0] fa;
    inc = incr_pc_o;
    fl  = flush_i;
    fa  = imem_addr_o;
    @(posedge clk_i);
    #2;
    if (fl) pc_i = redir;
    else if (inc) pc_i = pc_i + 32'd4;
    if (auto_mem) begin
      imem_rvalid_i = inc;
      imem_rdata_i  = data_of(fa);
      imem_err_i    = 1'b0;
    end
  endtask

  task automatic head_chk(input string tag);
    chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
    chk({tag, "_pc"}, instr_pc_o, exp_head);
    chk({tag, "_instr"}, instr_o, data_of(exp_head));
    if (instr_ready_i) exp_head = exp_head + 32'd4;
  endtask

  initial begin
    rst_i = 1'b1;
    pc_i = 32'h0;
    flush_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    imem_err_i = 1'b0;
    instr_ready_i = 1'b1;
    auto_mem = 1'b1;
    redir = 32'h0;
    exp_head = 32'h0;
    #3;
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_fault", {31'b0, instr_fault_o}, 32'd0);
    tick();
    rst_i = 1'b0;

    // streaming: gnt always, response at T+1, ready high
    imem_gnt_i = 1'b1;
    #1;
    chk("c0_req", {31'b0, imem_req_o}, 32'd1);
    chk("c0_addr", imem_addr_o, 32'h0);
    chk("c0_incr", {31'b0, incr_pc_o}, 32'd1);
    tick();
    #1;
    chk("c1_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("c1_addr", imem_addr_o, 32'h4);
    tick();
    #1;
    chk("c2_first", instr_o, 32'hAABB_CCDD);
    for (int i = 0; i < 5; i++) begin
      head_chk("stream");
      tick();
      #1;
    end

    // backpressure: two entries fill and requests stop
    instr_ready_i = 1'b0;
    #1;
    chk("bp0_req", {31'b0, imem_req_o}, 32'd0);
    head_chk("bp0");
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("bp_full_req", {31'b0, imem_req_o}, 32'd0);
      head_chk("bp_full");
    end
    tick();
    instr_ready_i = 1'b1;
    #1;
    chk("bp_pop_req", {31'b0, imem_req_o}, 32'd1);
    head_chk("bp_pop");
    tick();
    instr_ready_i = 1'b0;
    #1;
    chk("bp_refill_req", {31'b0, imem_req_o}, 32'd0);
    head_chk("bp_refill");
    tick();
    #1;
    chk("bp_full2_req", {31'b0, imem_req_o}, 32'd0);
    head_chk("bp_full2");
    tick();
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      head_chk("drain");
      tick();
    end

    // flush during WAIT+rvalid, then grant held off three cycles at 0x100
    flush_i = 1'b1;
    redir = 32'h100;
    imem_gnt_i = 1'b0;
    #1;
    chk("fl_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    exp_head = 32'h100;
    #1;
    chk("fl_empty", {31'b0, instr_valid_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", imem_addr_o, 32'h100);
      chk("stall_req", {31'b0, imem_req_o}, 32'd1);
      chk("stall_incr", {31'b0, incr_pc_o}, 32'd0);
      tick();
      #1;
    end
    imem_gnt_i = 1'b1;
    #1;
    chk("gnt_addr", imem_addr_o, 32'h100);
    chk("gnt_incr", {31'b0, incr_pc_o}, 32'd1);
    tick();
    imem_gnt_i = 1'b0;
    #1;
    chk("post_gnt_incr", {31'b0, incr_pc_o}, 32'd0);
    chk("post_gnt_addr", imem_addr_o, 32'h104);
    tick();

    // flush in WAIT without rvalid: late DEADBEEF must vanish
    auto_mem = 1'b0;
    instr_ready_i = 1'b0;
    imem_gnt_i = 1'b1;
    #1;
    head_chk("w0");
    tick();
    imem_rvalid_i = 1'b0;
    imem_gnt_i = 1'b0;
    flush_i = 1'b1;
    redir = 32'h80;
    #1;
    head_chk("w1");
    chk("w1_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("disc_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("disc_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("disc_gone", {31'b0, instr_valid_o}, 32'd0);
    chk("disc_instr", instr_o, NOP);
    chk("redir_req", {31'b0, imem_req_o}, 32'd1);
    chk("redir_addr", imem_addr_o, 32'h80);
    tick();

    // bus error at 0x40
    flush_i = 1'b1;
    redir = 32'h40;
    tick();
    flush_i = 1'b0;
    imem_gnt_i = 1'b1;
    #1;
    chk("e_addr", imem_addr_o, 32'h40);
    chk("e_incr", {31'b0, incr_pc_o}, 32'd1);
    tick();
    imem_rvalid_i = 1'b1;
    imem_err_i = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    #1;
    chk("e_rv_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    imem_err_i = 1'b0;
    #1;
    chk("e_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("e_fault", {31'b0, instr_fault_o}, 32'd1);
    chk("e_instr", instr_o, NOP);
    chk("e_pc", instr_pc_o, 32'h40);
    chk("e_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    instr_ready_i = 1'b1;
    #1;
    chk("e_hold_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    instr_ready_i = 1'b0;
    #1;
    chk("e_drained", {31'b0, instr_valid_o}, 32'd0);
    chk("e_nofault", {31'b0, instr_fault_o}, 32'd0);
    chk("e_stopped", {31'b0, imem_req_o}, 32'd0);
    tick();
    flush_i = 1'b1;
    redir = 32'h200;
    tick();
    flush_i = 1'b0;
    #1;
    chk("e_resume_req", {31'b0, imem_req_o}, 32'd1);
    chk("e_resume_addr", imem_addr_o, 32'h200);
    tick();

    // flush coincident with rvalid
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h1111_1111;
    flush_i = 1'b1;
    redir = 32'h300;
    #1;
    chk("fr_req", {31'b0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("fr_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("fr_addr", imem_addr_o, 32'h300);
    chk("fr_incr", {31'b0, incr_pc_o}, 32'd1);
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h2222_2222;
    imem_gnt_i = 1'b0;
    tick();
    imem_rvalid_i = 1'b0;
    imem_gnt_i = 1'b1;
    #1;
    chk("pre_rst_instr", instr_o, 32'h2222_2222);
    chk("pre_rst_pc", instr_pc_o, 32'h300);
    tick();

    // reset while WAIT with a buffered entry
    imem_gnt_i = 1'b0;
    #1;
    chk("wait_valid", {31'b0, instr_valid_o}, 32'd1);
    rst_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h3333_3333;
    #1;
    chk("ar_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("ar_instr", instr_o, NOP);
    chk("ar_pc", instr_pc_o, 32'h0);
    chk("ar_fault", {31'b0, instr_fault_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_gnt_i = 1'b1;
    #1;
    chk("rr_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rr_req", {31'b0, imem_req_o}, 32'd1);
    chk("rr_addr", imem_addr_o, 32'h308);
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h4444_4444;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("rr_instr", instr_o, 32'h4444_4444);
    chk("rr_pc", instr_pc_o, 32'h308);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit between the program counter unit and instruction memory. It issues one fetch request per PC, with at most one outstanding. Accepted requests pulse `incr_pc_o` back to the PC unit. Returned words go into a 2-entry instruction buffer, tagged with their PC, and decode drains that buffer through a valid/ready handshake. A redirect (`flush_i`) empties the buffer and drops any in-flight response.

## Interface
- `NOP_INSTR`, default 32'h0000_0013: word presented on `instr_o` when the buffer is empty or the entry carries a fault.
- `clk_i` in 1: clock, all flops on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `pc_i` in 32: current fetch PC from the PC unit.
- `flush_i` in 1: redirect (exception, branch, or return) this cycle; the new PC appears on `pc_i` the next cycle.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, equal to `pc_i`.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid.
- `imem_rdata_i` in 32: response data.
- `imem_err_i` in 1: response bus error, qualified by `imem_rvalid_i`.
- `incr_pc_o` out 1: advance the PC by 4.
- `instr_valid_o` out 1: buffer head is valid.
- `instr_o` out 32: buffer head instruction.
- `instr_pc_o` out 32: PC of the buffer head.
- `instr_fault_o` out 1: buffer head carries a fetch error.
- `instr_ready_i` in 1: decode accepts the head this cycle.

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DISCARD: outstanding response is to be dropped.
  - FAULTED: fetching stopped after an error.
- Define the signals:
  - `pop = instr_valid_o & instr_ready_i`
  - `out = (state==WAIT)`
  - `cnt`: buffer occupancy, 0..2
- `imem_req_o = !flush_i & (state==IDLE | (state==WAIT & imem_rvalid_i & !imem_err_i)) & (cnt - pop + out < 2)`.
- `incr_pc_o = imem_req_o & imem_gnt_i`, combinational.
- On `imem_req_o & imem_gnt_i`: latch `pc_i` into `pend_pc` and go to WAIT.
- While `imem_req_o` is high without `gnt`, the address holds. `pc_i` does not move, because `incr_pc_o` is low.
- WAIT with `imem_rvalid_i` and no flush:
  - Push {`rdata`, `pend_pc`, `err`} into the buffer.
  - If `err`: push with fault=1 and go to FAULTED.
  - Otherwise go to IDLE, or stay in WAIT if a new request is granted the same cycle.
- FAULTED: no requests. The buffer still drains. `flush_i` returns the block to IDLE.
- `flush_i` has highest priority:
  - The buffer is cleared at the next edge (`cnt`→0).
  - WAIT without `rvalid` → DISCARD.
  - WAIT with `rvalid` → response dropped → IDLE.
  - IDLE or FAULTED → IDLE.
  - DISCARD → DISCARD.
- DISCARD: no requests. The first `rvalid` is dropped and the state goes to IDLE. A `rvalid` arriving in the same cycle as `flush_i` is also just dropped, and the state goes to IDLE.
- Buffer: 2-entry FIFO.
  - Push and pop in the same cycle are both legal; `cnt` stays the same.
  - A pop of an entry with fault=1 proceeds as normal.
  - Overflow cannot occur by construction; an assertion checks it.
- Output mux:
  - `instr_valid_o = cnt != 0`.
  - `instr_o = (cnt==0 | head.fault) ? NOP_INSTR : head.data`.
- Reset (async, `rst_i`=1):
  - state IDLE, `cnt`=0, `pend_pc`=0.
  - `instr_valid_o`=0, `instr_o`=NOP_INSTR, `instr_pc_o`=0, `instr_fault_o`=0.
  - `imem_req_o` high in the first cycle after release (unless `flush_i`).
  - An `rvalid` for a request issued before reset is the memory's responsibility to suppress.

## Timing
- Memory must not assert `rvalid` earlier than the cycle after `gnt`.
- Grant at cycle T:
  - `incr_pc_o`=1 at T.
  - `pc_i`=old+4 at T+1.
  - Earliest `rvalid` at T+1.
  - `instr_valid_o` at T+2.
- Minimum `gnt`→`instr_valid_o` latency is 2 cycles.
- Throughput is 1 instruction/cycle when memory answers at T+1 and decode pops every cycle.
- `flush_i` at cycle F:
  - `imem_req_o`=0 at F.
  - `instr_valid_o`=0 at F+1.
  - First request to the redirected PC at F+1 if in IDLE, otherwise at the cycle after the drop.
- `instr_ready_i` with an empty buffer is ignored.

## Test plan
- Reset release, `pc_i`=0x0000_0000, `gnt` always high, `rvalid` at T+1 with data 0xAABB_CCDD, ready high:
  - `instr_o`=0xAABB_CCDD, `instr_pc_o`=0x0 at cycle 2.
  - `instr_valid_o` continuous from then on, PCs 0x0, 0x4, 0x8, …
- Ready held low: exactly 2 entries are buffered and `imem_req_o` drops. Ready then rises for 1 cycle: one request reissues and `cnt` returns to 2. No entry is lost and PC order is preserved.
- `gnt` delayed 3 cycles with `pc_i`=0x100: `imem_addr_o` holds 0x100, `incr_pc_o`=0 until `gnt`, then a single pulse.
- Flush while in WAIT (no `rvalid`), `pc_i`→0x80:
  - Buffer empties next cycle.
  - The late `rvalid` data 0xDEAD_BEEF is never visible.
  - The next request has address 0x80.
- `rvalid` with `err` for PC 0x40:
  - `instr_fault_o`=1, `instr_o`=0x0000_0013, `instr_pc_o`=0x40.
  - No further requests until `flush_i`, then fetching resumes at the new PC.
- Flush coincident with `rvalid`, and `rst_i` asserted mid-WAIT: data is dropped, state goes to IDLE, all outputs go to their reset values immediately on `rst_i`.
